// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    // Transaction sequencer states; the encoding is visible to debug tools.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Main memory window: 1 MB starting at 0x80000000.
    localparam logic [31:0] MEM_BASE = 32'h8000_0000;
    localparam logic [31:0] MEM_MASK = 32'hFFF0_0000;

    // Requester identities; port 0 is instruction fetch, port 1 is load/store.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // True when an address falls inside the main memory window.
    function automatic logic addr_in_mem(input logic [31:0] addr);
        return (addr & MEM_MASK) == MEM_BASE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's request/response channel into the memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: request uses valid/ready, response uses valid/ready.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // Requester side.
    modport master (
        output req_valid, rw, address, write_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, rw, address, write_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker with its own last-grant register.
// Latency: grant is combinational from i_valid; last-grant updates on the clock edge.
// Backpressure: none; i_update commits the current grant as the new last-grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_last;

    // Sole requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last == PORT0) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Remember who won; resets to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT1;
        end else if (i_update && (o_grant != 2'b00)) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer from two requesters onto a single-port memory (optional MEM_ARB_PERF_EN counters).
// Latency: accept at N, memory access at N+1, response valid from N+2; at least 3 cycles per transaction.
// Backpressure: one transaction in flight; no request accepted until the owning port takes its response.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      r0,
    mem_arbiter_if.slave      r1,
    output logic              mem_rw,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_selected,
    input  logic              mem_misaligned
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_err
`endif
);

    state_t            r_state;
    state_t            w_next;

    logic              r_port;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;

    logic              w_idle;
    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_err;
    logic              w_resp_rdy;
    logic              w_sel_rw;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // Only offer requests to the picker while idle, so grants (and req_ready) are zero otherwise.
    assign w_idle   = (r_state == IDLE);
    assign w_valid  = w_idle ? {r1.req_valid, r0.req_valid} : 2'b00;
    assign w_accept = (w_grant != 2'b00);

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (w_valid),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    // Request fields of whichever port is being granted.
    assign w_sel_rw    = w_grant[1] ? r1.rw         : r0.rw;
    assign w_sel_addr  = w_grant[1] ? r1.address    : r0.address;
    assign w_sel_wdata = w_grant[1] ? r1.write_data : r0.write_data;

    // A fault is any access the memory reports as misaligned or not decoded.
    assign w_err      = mem_misaligned | ~mem_selected;
    assign w_resp_rdy = (r_port == PORT1) ? r1.resp_ready : r0.resp_ready;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory-side drive; memory sees a live address for the ACCESS cycle only.
    always_comb begin
        w_next         = r_state;
        mem_rw         = 1'b0;
        mem_address    = IDLE_ADDR;
        mem_write_data = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_address    = 32'(r_addr);
                mem_write_data = r_wdata;
                // A faulting write never reaches the array.
                mem_rw         = r_rw & ~w_err;
                w_next         = RESP;
            end
            RESP: begin
                if (w_resp_rdy) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the granted request on accept and capture the memory result during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port      <= PORT0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_port  <= w_grant[1];
                r_rw    <= w_sel_rw;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == ACCESS) begin
                // Writes and faults return zero data so stale array contents never leak.
                r_resp_data <= (!r_rw && !w_err) ? mem_read_data : '0;
                r_resp_err  <= w_err;
            end
        end
    end

    // Requester-facing handshake; response payload is shared, valid goes to the owner only.
    assign r0.req_ready  = w_grant[0];
    assign r1.req_ready  = w_grant[1];
    assign r0.resp_valid = (r_state == RESP) && (r_port == PORT0);
    assign r1.resp_valid = (r_state == RESP) && (r_port == PORT1);
    assign r0.resp_data  = r_resp_data;
    assign r1.resp_data  = r_resp_data;
    assign r0.resp_err   = r_resp_err;
    assign r1.resp_err   = r_resp_err;

`ifdef MEM_ARB_PERF_EN
    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_err    <= '0;
        end else begin
            if (w_grant[0]) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (w_grant[1]) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if ((r_state == ACCESS) && w_err) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized traffic.
// Latency: checks accept->access->response spacing of 1 and 2 cycles.
// Backpressure: drives random resp_ready and checks no accept while a transaction is open.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] TB_IDLE = 32'h0000_0000;

    bit clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r0_if ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) r1_if ();

    logic        mem_rw;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_selected;
    logic        mem_misaligned;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_err;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IDLE_ADDR(TB_IDLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r0             (r0_if),
        .r1             (r1_if),
        .mem_rw         (mem_rw),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_selected   (mem_selected),
        .mem_misaligned (mem_misaligned)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant0    (perf_grant0),
        .perf_grant1    (perf_grant1),
        .perf_err       (perf_err)
`endif
    );

    // Initial contents of any memory word.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: first 4 KB of the window backed by storage; unmapped reads return junk.
    logic [31:0] tb_mem [0:1023];
    bit          mem_ready = 1'b0;
    assign mem_selected   = addr_in_mem(mem_address);
    assign mem_misaligned = (mem_address[1:0] != 2'b00);
    assign mem_read_data  = mem_selected ? tb_mem[mem_address[11:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_val(32'h8000_0000 + 32'(i * 4));
            mem_ready <= 1'b1;
        end else if (mem_rw && mem_selected && !mem_misaligned) begin
            tb_mem[mem_address[11:2]] <= mem_write_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic        port;
        logic        rw;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          m_busy = 1'b0;
    logic        m_last = 1'b1;
    bit          m_seen = 1'b0;
    int          acc_cyc = -100;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_wdata = '0;
    logic        acc_mrw = 1'b0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return (last == 1'b0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, compares DUT against the model.
    always @(negedge clk) begin
        logic [1:0]  vld, rdy, acc, rv, exp_rdy;
        logic [31:0] a, rdat;
        logic        p, rw, err, rerr, rrdy;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_req_ready",  {30'd0, r1_if.req_ready, r0_if.req_ready}, 32'd0);
            chk("rst_resp_valid", {30'd0, r1_if.resp_valid, r0_if.resp_valid}, 32'd0);
            chk("rst_resp_data0", r0_if.resp_data, 32'd0);
            chk("rst_resp_data1", r1_if.resp_data, 32'd0);
            chk("rst_resp_err",   {30'd0, r1_if.resp_err, r0_if.resp_err}, 32'd0);
            chk("rst_mem_rw",     {31'd0, mem_rw}, 32'd0);
            chk("rst_mem_addr",   mem_address, TB_IDLE);
            chk("rst_mem_wdata",  mem_write_data, 32'd0);
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_seen  = 1'b0;
            acc_cyc = -100;
            exp_q.delete();
        end else begin
            vld = {r1_if.req_valid, r0_if.req_valid};
            rdy = {r1_if.req_ready, r0_if.req_ready};
            exp_rdy = m_busy ? 2'b00 : rr_pick(vld, m_last);
            chk("req_ready", {30'd0, rdy}, {30'd0, exp_rdy});

            if (cyc == acc_cyc + 1) begin
                chk("access_addr", mem_address, acc_addr);
                chk("access_rw", {31'd0, mem_rw}, {31'd0, acc_mrw});
                if (acc_mrw) chk("access_wdata", mem_write_data, acc_wdata);
            end else begin
                chk("idle_mem_rw", {31'd0, mem_rw}, 32'd0);
                chk("idle_mem_addr", mem_address, TB_IDLE);
            end

            rv = {r1_if.resp_valid, r0_if.resp_valid};
            if (rv != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {30'd0, rv}, 32'd0);
                end else begin
                    e    = exp_q[0];
                    rdat = rv[1] ? r1_if.resp_data : r0_if.resp_data;
                    rerr = rv[1] ? r1_if.resp_err  : r0_if.resp_err;
                    rrdy = rv[1] ? r1_if.resp_ready : r0_if.resp_ready;
                    chk("resp_port", {30'd0, rv}, e.port ? 32'd2 : 32'd1);
                    chk("resp_data", rdat, e.data);
                    chk("resp_err", {31'd0, rerr}, {31'd0, e.err});
                    if (!m_seen) chk("resp_latency", cyc - acc_cyc, 32'd2);
                    m_seen = 1'b1;
                    if (rrdy) begin
                        if (e.rw && !e.err) ref_mem[e.addr] = e.wdata;
                        void'(exp_q.pop_front());
                        m_busy = 1'b0;
                        m_seen = 1'b0;
                    end
                end
            end else if (m_busy && (cyc - acc_cyc > 60)) begin
                chk("resp_timeout", cyc - acc_cyc, 32'd2);
                m_busy = 1'b0;
                exp_q.delete();
            end

            acc = vld & rdy;
            if (acc != 2'b00) begin
                p   = acc[1];
                rw  = p ? r1_if.rw : r0_if.rw;
                a   = p ? r1_if.address : r0_if.address;
                err = (a[1:0] != 2'b00) || !addr_in_mem(a);
                e.port  = p;
                e.rw    = rw;
                e.err   = err;
                e.addr  = a;
                e.wdata = p ? r1_if.write_data : r0_if.write_data;
                e.data  = (!rw && !err) ? ref_rd(a) : 32'd0;
                exp_q.push_back(e);
                m_busy    = 1'b1;
                m_last    = p;
                m_seen    = 1'b0;
                acc_cyc   = cyc;
                acc_addr  = a;
                acc_wdata = e.wdata;
                acc_mrw   = rw & ~err;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int p, input logic v, input logic rw, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            r0_if.req_valid = v; r0_if.rw = rw; r0_if.address = a; r0_if.write_data = d;
        end else begin
            r1_if.req_valid = v; r1_if.rw = rw; r1_if.address = a; r1_if.write_data = d;
        end
    endtask

    // Issue one request and hold it until accepted (bounded); returns 1 ns into the ACCESS cycle.
    task automatic req(input int p, input logic rw, input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        drive(p, 1'b1, rw, a, d);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? (r0_if.req_valid & r0_if.req_ready) : (r1_if.req_valid & r1_if.req_ready);
            @(posedge clk); #1;
        end
        drive(p, 1'b0, rw, a, d);
    endtask

    task automatic rand_fields(output logic rw, output logic [31:0] a, output logic [31:0] d);
        int k = $urandom_range(0, 9);
        rw = 1'($urandom_range(0, 1));
        d  = $urandom;
        if (k == 0)      a = 32'h0000_1000 + 32'($urandom_range(0, 3) * 4);
        else if (k == 1) a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        else             a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
    endtask

    initial begin
        logic        rw;
        logic [31:0] a, d;
        bit          a0, a1;
        int          n_acc;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        r0_if.resp_ready = 1'b1;
        r1_if.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single read, then write-then-read across ports, then misaligned write and its read-back.
        req(0, 1'b0, 32'h8000_0010, 32'd0);
        req(1, 1'b1, 32'h8000_0004, 32'h1234_5678);
        req(0, 1'b0, 32'h8000_0004, 32'd0);
        req(1, 1'b1, 32'h8000_0002, 32'hFFFF_FFFF);
        req(1, 1'b0, 32'h8000_0000, 32'd0);

        // Unmapped read under 5+ cycles of response back-pressure with a competing request.
        r0_if.resp_ready = 1'b0;
        req(0, 1'b0, 32'h0000_1000, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h8000_0008, 32'd0);
        repeat (7) @(posedge clk); #1;
        r0_if.resp_ready = 1'b1;
        req(1, 1'b0, 32'h8000_0008, 32'd0);
        repeat (5) @(posedge clk); #1;

        // Reset during the ACCESS cycle of a write; the write must not land.
        req(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req(0, 1'b0, 32'h8000_0020, 32'd0);
        repeat (4) @(posedge clk); #1;

        // Contention straight out of reset: both ports stay valid for 4 accepts.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8000_0030, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h8000_0034, 32'd0);
        n_acc = 0;
        for (int i = 0; i < 60 && n_acc < 4; i++) begin
            @(negedge clk);
            a0 = r0_if.req_valid & r0_if.req_ready;
            a1 = r1_if.req_valid & r1_if.req_ready;
            @(posedge clk); #1;
            if (a0) begin n_acc++; drive(0, 1'b1, 1'b0, 32'h8000_0038 + 32'(n_acc * 8), 32'd0); end
            if (a1) begin n_acc++; drive(1, 1'b1, 1'b0, 32'h8000_003C + 32'(n_acc * 8), 32'd0); end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clk); #1;

        // Randomized traffic with withdrawals and random response back-pressure.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = r0_if.req_valid & r0_if.req_ready;
            a1 = r1_if.req_valid & r1_if.req_ready;
            @(posedge clk); #1;
            if (a0 || (r0_if.req_valid && $urandom_range(0, 19) == 0)) r0_if.req_valid = 1'b0;
            else if (!r0_if.req_valid && $urandom_range(0, 1) == 1) begin
                rand_fields(rw, a, d); drive(0, 1'b1, rw, a, d);
            end
            if (a1 || (r1_if.req_valid && $urandom_range(0, 19) == 0)) r1_if.req_valid = 1'b0;
            else if (!r1_if.req_valid && $urandom_range(0, 1) == 1) begin
                rand_fields(rw, a, d); drive(1, 1'b1, rw, a, d);
            end
            r0_if.resp_ready = ($urandom_range(0, 9) < 7);
            r1_if.resp_ready = ($urandom_range(0, 9) < 7);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        r0_if.resp_ready = 1'b1;
        r1_if.resp_ready = 1'b1;
        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
